// File: rtl/tag_lookup_unit.sv
// N-way set-associative tag/valid store with registered hit/way/victim lookup response.
// Define TAG_LOOKUP_MULTIHIT_EN to compute resp_multihit; otherwise it is tied low.
//
//  state | meaning
//  IDLE  | lookups and fills accepted
//  FLUSH | clearing valid bits and rr pointers of set r_cnt, one set per cycle
module tag_lookup_unit #(
    parameter int TAG_BITS = 12,
    parameter int WAYS     = 4,
    parameter int SETS     = 64,
    localparam int WB      = $clog2(WAYS),
    localparam int IB      = $clog2(SETS)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_lookup_valid,
    output logic                o_lookup_ready,
    input  logic [IB-1:0]       i_lookup_index,
    input  logic [TAG_BITS-1:0] i_lookup_tag,
    output logic                o_resp_valid,
    input  logic                i_resp_ready,
    output logic                o_resp_hit,
    output logic [WB-1:0]       o_resp_way,
    output logic [WB-1:0]       o_resp_victim,
    output logic                o_resp_multihit,
    input  logic                i_fill_valid,
    input  logic [IB-1:0]       i_fill_index,
    input  logic [WB-1:0]       i_fill_way,
    input  logic [TAG_BITS-1:0] i_fill_tag,
    input  logic                i_flush_req,
    output logic                o_flush_busy
);

    typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

    state_t                r_state;
    logic [IB-1:0]         r_cnt;
    logic                  r_flush_busy;

    logic [TAG_BITS-1:0]   r_tag   [SETS][WAYS];
    logic [WAYS-1:0]       r_valid [SETS];
    logic [WB-1:0]         r_rr    [SETS];

    logic                  r_resp_valid;
    logic                  r_resp_hit;
    logic [WB-1:0]         r_resp_way;
    logic [WB-1:0]         r_resp_victim;
    logic                  r_resp_multihit;

    logic [WAYS-1:0]       w_match;
    logic                  w_hit;
    logic [WB-1:0]         w_hit_way;
    logic [WB-1:0]         w_victim;
    logic                  w_multihit;
    logic                  w_accept;
    logic                  w_fill_en;

    assign o_lookup_ready  = (r_state == ST_IDLE) && (!r_resp_valid || i_resp_ready);
    assign w_accept        = i_lookup_valid && o_lookup_ready;
    assign w_fill_en       = i_fill_valid && (r_state != ST_FLUSH);

    assign o_resp_valid    = r_resp_valid;
    assign o_resp_hit      = r_resp_hit;
    assign o_resp_way      = r_resp_way;
    assign o_resp_victim   = r_resp_victim;
    assign o_resp_multihit = r_resp_multihit;
    assign o_flush_busy    = r_flush_busy;

    always_comb begin
        w_match = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_match[w] = r_valid[i_lookup_index][w] &&
                         (r_tag[i_lookup_index][w] == i_lookup_tag);
        end
    end

    assign w_hit = |w_match;

    // Scan from the top so the lowest-numbered match wins.
    always_comb begin
        w_hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_match[w]) begin
                w_hit_way = WB'(w);
            end
        end
    end

    always_comb begin
        w_victim = r_rr[i_lookup_index];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[i_lookup_index][w]) begin
                w_victim = WB'(w);
            end
        end
    end

`ifdef TAG_LOOKUP_MULTIHIT_EN
    logic [WB:0] w_match_cnt;

    always_comb begin
        w_match_cnt = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_match_cnt = w_match_cnt + (WB + 1)'(w_match[w]);
        end
    end

    assign w_multihit = (w_match_cnt > (WB + 1)'(1));
`else
    assign w_multihit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_flush_busy <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_flush_req) begin
                        r_state      <= ST_FLUSH;
                        r_cnt        <= '0;
                        r_flush_busy <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (r_cnt == IB'(SETS - 1)) begin
                        r_state      <= ST_IDLE;
                        r_cnt        <= '0;
                        r_flush_busy <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + IB'(1);
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_cnt        <= '0;
                    r_flush_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else if (r_state == ST_FLUSH) begin
            r_valid[r_cnt] <= '0;
            r_rr[r_cnt]    <= '0;
        end else if (i_fill_valid) begin
            r_valid[i_fill_index][i_fill_way] <= 1'b1;
            r_rr[i_fill_index]                <= i_fill_way + WB'(1);
        end
    end

    // Tags carry no reset; a tag is only meaningful while its valid bit is set.
    always_ff @(posedge i_clk) begin
        if (w_fill_en) begin
            r_tag[i_fill_index][i_fill_way] <= i_fill_tag;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_resp_valid    <= 1'b0;
            r_resp_hit      <= 1'b0;
            r_resp_way      <= '0;
            r_resp_victim   <= '0;
            r_resp_multihit <= 1'b0;
        end else if (w_accept) begin
            r_resp_valid    <= 1'b1;
            r_resp_hit      <= w_hit;
            r_resp_way      <= w_hit_way;
            r_resp_victim   <= w_victim;
            r_resp_multihit <= w_multihit;
        end else if (i_resp_ready) begin
            r_resp_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tag_lookup_unit.sv
// Directed plus randomized bench for tag_lookup_unit against a set/way array reference model.
module tb_tag_lookup_unit;

    localparam int TAG_BITS = 12;
    localparam int WAYS     = 4;
    localparam int SETS     = 64;
    localparam int WB       = $clog2(WAYS);
    localparam int IB       = $clog2(SETS);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                lookup_valid = 1'b0;
    logic                lookup_ready;
    logic [IB-1:0]       lookup_index = '0;
    logic [TAG_BITS-1:0] lookup_tag = '0;
    logic                resp_valid;
    logic                resp_ready = 1'b1;
    logic                resp_hit;
    logic [WB-1:0]       resp_way;
    logic [WB-1:0]       resp_victim;
    logic                resp_multihit;
    logic                fill_valid = 1'b0;
    logic [IB-1:0]       fill_index = '0;
    logic [WB-1:0]       fill_way = '0;
    logic [TAG_BITS-1:0] fill_tag = '0;
    logic                flush_req = 1'b0;
    logic                flush_busy;

    int checks = 0;
    int errors = 0;

    // Reference model: plain arrays of tags/valid flags plus response registers.
    int  m_tag   [SETS][WAYS];
    bit  m_valid [SETS][WAYS];
    int  m_rr    [SETS];
    int  m_flush_left;
    bit  m_rv, m_hit, m_mh;
    int  m_way, m_vic;

    tag_lookup_unit #(.TAG_BITS(TAG_BITS), .WAYS(WAYS), .SETS(SETS)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_lookup_valid  (lookup_valid),
        .o_lookup_ready  (lookup_ready),
        .i_lookup_index  (lookup_index),
        .i_lookup_tag    (lookup_tag),
        .o_resp_valid    (resp_valid),
        .i_resp_ready    (resp_ready),
        .o_resp_hit      (resp_hit),
        .o_resp_way      (resp_way),
        .o_resp_victim   (resp_victim),
        .o_resp_multihit (resp_multihit),
        .i_fill_valid    (fill_valid),
        .i_fill_index    (fill_index),
        .i_fill_way      (fill_way),
        .i_fill_tag      (fill_tag),
        .i_flush_req     (flush_req),
        .o_flush_busy    (flush_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
        m_flush_left = 0;
        m_rv = 0; m_hit = 0; m_mh = 0; m_way = 0; m_vic = 0;
    endtask

    task automatic idle_inputs();
        lookup_valid = 1'b0;
        fill_valid   = 1'b0;
        flush_req    = 1'b0;
        resp_ready   = 1'b1;
    endtask

    // One clock: check ready against the model, clock, advance the model, check outputs.
    task automatic step();
        bit rdy, acc, fill_ok, hit, mh, found;
        int way, vic, nmatch, idx;
        #1;
        rdy = (m_flush_left == 0) && (!m_rv || resp_ready);
        chk("lookup_ready", lookup_ready, rdy);
        acc = lookup_valid && rdy;
        idx = int'(lookup_index);
        hit = 0; way = 0; nmatch = 0; found = 0; vic = m_rr[idx];
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[idx][w] && m_tag[idx][w] == int'(lookup_tag)) begin
                if (!hit) way = w;
                hit = 1;
                nmatch++;
            end
            if (!m_valid[idx][w] && !found) begin
                vic = w;
                found = 1;
            end
        end
`ifdef TAG_LOOKUP_MULTIHIT_EN
        mh = (nmatch > 1);
`else
        mh = 0;
`endif
        fill_ok = fill_valid && (m_flush_left == 0);
        @(posedge clk);
        #1;
        if (acc) begin
            m_rv = 1; m_hit = hit; m_way = way; m_vic = vic; m_mh = mh;
        end else if (resp_ready) begin
            m_rv = 0;
        end
        if (m_flush_left > 0) begin
            int s;
            s = SETS - m_flush_left;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
            m_rr[s] = 0;
            m_flush_left--;
        end else if (flush_req) begin
            m_flush_left = SETS;
        end
        if (fill_ok) begin
            m_tag[fill_index][fill_way]   = int'(fill_tag);
            m_valid[fill_index][fill_way] = 1'b1;
            m_rr[fill_index]              = (int'(fill_way) + 1) % WAYS;
        end
        chk("resp_valid", resp_valid, m_rv);
        chk("resp_hit", resp_hit, m_hit);
        chk("resp_way", resp_way, m_way);
        chk("resp_victim", resp_victim, m_vic);
        chk("resp_multihit", resp_multihit, m_mh);
        chk("flush_busy", flush_busy, m_flush_left > 0);
    endtask

    task automatic lookup(input int idx, input int tag);
        idle_inputs();
        lookup_valid = 1'b1;
        lookup_index = IB'(idx);
        lookup_tag   = TAG_BITS'(tag);
        step();
        lookup_valid = 1'b0;
    endtask

    task automatic fill(input int idx, input int way, input int tag);
        idle_inputs();
        fill_valid = 1'b1;
        fill_index = IB'(idx);
        fill_way   = WB'(way);
        fill_tag   = TAG_BITS'(tag);
        step();
        fill_valid = 1'b0;
    endtask

    initial begin
        int busy_cycles;
        model_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        // Cold miss: victim is the lowest invalid way.
        lookup(5, 'h123);
        fill(5, 2, 'h123);
        lookup(5, 'h123);
        step();

        // Full set: victim comes from the round-robin pointer.
        fill(7, 0, 'h0A0);
        fill(7, 2, 'h0A2);
        fill(7, 3, 'h0A3);
        fill(7, 1, 'h0A1);
        lookup(7, 'h7FF);
        chk("victim_rr", resp_victim, 2);
        fill(7, 0, 'h055);
        fill(7, 3, 'h055);
        lookup(7, 'h055);
        chk("multihit_way", resp_way, 0);

        // Back-pressure: response held while lookups wait.
        fill(9, 1, 'h321);
        lookup(9, 'h321);
        lookup_valid = 1'b1;
        lookup_index = IB'(5);
        lookup_tag   = TAG_BITS'('h123);
        resp_ready   = 1'b0;
        repeat (3) step();
        resp_ready = 1'b1;
        step();
        step();
        lookup_valid = 1'b0;
        step();

        // Flush with a lookup accepted in the same cycle and a fill dropped mid-flush.
        lookup_valid = 1'b1;
        lookup_index = IB'(9);
        lookup_tag   = TAG_BITS'('h321);
        flush_req    = 1'b1;
        step();
        flush_req  = 1'b0;
        busy_cycles = 1;
        for (int c = 0; c < SETS + 4; c++) begin
            fill_valid = (c == 10);
            fill_index = IB'(11);
            fill_way   = WB'(0);
            fill_tag   = TAG_BITS'('h777);
            step();
            if (flush_busy) busy_cycles++;
        end
        fill_valid = 1'b0;
        lookup_valid = 1'b0;
        chk("flush_busy_cycles", busy_cycles, SETS);
        lookup(5, 'h123);
        lookup(7, 'h055);
        lookup(9, 'h321);
        lookup(11, 'h777);
        chk("after_flush_hit", resp_hit, 0);

        // Reset in the middle of a flush.
        fill(3, 1, 'h0BB);
        lookup(3, 'h0BB);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        chk("rst_flush_busy", flush_busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        model_reset();
        #2 rst_n = 1'b1;
        lookup(3, 'h0BB);
        lookup(3, 'h0BB);

        // Randomized traffic confined to a few sets so hits and multihits occur.
        for (int c = 0; c < 600; c++) begin
            lookup_valid = ($urandom_range(0, 3) != 0);
            lookup_index = IB'($urandom_range(0, 3));
            lookup_tag   = TAG_BITS'($urandom_range(0, 5));
            resp_ready   = ($urandom_range(0, 3) != 0);
            fill_valid   = ($urandom_range(0, 2) == 0);
            fill_index   = IB'($urandom_range(0, 3));
            fill_way     = WB'($urandom_range(0, WAYS - 1));
            fill_tag     = TAG_BITS'($urandom_range(0, 5));
            flush_req    = ($urandom_range(0, 199) == 0);
            step();
        end
        idle_inputs();
        repeat (SETS + 2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tag_lookup_unit.md
# tag_lookup_unit

Parameterised N-way set-associative tag lookup stage for the L2 cache model. Holds a tag/valid store of SETS x WAYS entries, accepts lookups through a valid/ready handshake, and returns a registered hit/way/victim response one cycle later. Fill writes install tags, and a flush state machine clears all valid bits. It replaces the single-tag combinational compare on the L2 lookup path.

## Interface
- TAG_BITS, 12, tag width
- WAYS, 4, associativity (power of two, >=2); WB = clog2(WAYS)
- SETS, 64, number of sets (power of two); IB = clog2(SETS)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- lookup_valid  in  1  lookup request present
- lookup_ready  out  1  unit can accept a lookup
- lookup_index  in  IB  set index
- lookup_tag  in  TAG_BITS  address tag
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_hit  out  1  a valid way matched
- resp_way  out  WB  matching way; lowest-numbered match on multi-hit; 0 on miss
- resp_victim  out  WB  replacement way for this set
- resp_multihit  out  1  more than one valid way matched
- fill_valid  in  1  install fill_tag into fill_index/fill_way and set its valid bit
- fill_index  in  IB; fill_way  in  WB; fill_tag  in  TAG_BITS
- flush_req  in  1  start clearing all valid bits
- flush_busy  out  1  flush in progress

## Operation
- Storage: tag[SETS][WAYS], valid[SETS][WAYS], rr_ptr[SETS] (WB bits each).
- Lookup is accepted on lookup_valid && lookup_ready. The compare uses the pre-edge store contents: way w matches if valid[idx][w] && tag[idx][w] == lookup_tag.
- Victim selection: lowest-numbered invalid way in the set. If all ways are valid, use rr_ptr[idx].
- Fill: on fill_valid (not flushing), write tag and valid, then set rr_ptr[fill_index] = (fill_way+1) mod WAYS. Fills are accepted regardless of the handshake state.
- FSM states:
  - IDLE: flush_req goes to FLUSH with cnt=0.
  - FLUSH: clear valid[cnt][*] and reset rr_ptr[cnt] to 0. When cnt==SETS-1, go to IDLE; otherwise cnt++.
  - flush_req while in FLUSH is ignored.
  - Fills while in FLUSH are dropped.
- lookup_ready = (state==IDLE) && (!resp_valid || resp_ready).
- A pending response is held unchanged through a flush.

## Timing
- Reset values:
  - Outputs: resp_valid=0, resp_hit=0, resp_way=0, resp_victim=0, resp_multihit=0, flush_busy=0, lookup_ready=1 (once rst_n is high).
  - State: every valid bit=0, every rr_ptr=0, state IDLE, cnt=0.
  - Tags are not reset.
- Reset asserted mid-flush or mid-handshake aborts immediately to the reset state.
- Latency: a lookup accepted at edge N has its response registered and visible after edge N. Throughput is one lookup per cycle while resp_ready=1.
- Response fields are stable while resp_valid && !resp_ready.
- Fill and lookup to the same set in the same cycle: the lookup sees the old contents, and the fill is visible to lookups accepted from the next cycle on.
- flush_busy is high for exactly SETS cycles, starting the cycle after flush_req is sampled. lookup_ready is low for those cycles.
- flush_req sampled in the same cycle as a lookup acceptance: the lookup completes against pre-flush contents.

## Configuration
- TAG_LOOKUP_MULTIHIT_EN defined:
  - resp_multihit = population count of matches > 1.
  - resp_way is the lowest matching way.
- TAG_LOOKUP_MULTIHIT_EN undefined:
  - resp_multihit is tied to 0 and there is no popcount logic.
  - resp_way is still the lowest matching way.

## Test plan
- Reset, then lookup idx 5 tag 0x123 -> resp_hit=0, resp_victim=0, response one cycle after acceptance.
- Fill idx 5 way 2 tag 0x123, then lookup idx 5 tag 0x123 -> resp_hit=1, resp_way=2, resp_victim=0.
- Fill all 4 ways of idx 7, last fill to way 1, then lookup idx 7 miss -> resp_victim=2 (rr_ptr). Fill same way/tag into ways 0 and 3 -> resp_multihit=1 with macro, resp_way=0; resp_multihit=0 without macro.
- Hold resp_ready=0 for 3 cycles with lookup_valid=1 -> lookup_ready=0, response fields stable; release -> next lookup accepted that cycle.
- After fills, pulse flush_req -> flush_busy high exactly SETS cycles, lookups stall; a fill during the flush is dropped; afterwards every prior tag misses.
- Assert rst_n=0 mid-flush -> flush_busy=0 and all valid bits=0 immediately; a lookup after release misses.
